// File: rtl/fnn_layer_sequencer.sv
// ============================================================================
// fnn_layer_sequencer : per-frame layer sequencer with watchdog and result handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module fnn_layer_sequencer #(
  parameter  int NUM_LAYERS = 3,
  parameter  int TIMEOUT    = 4096,
  localparam int LAYER_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic               first,
  output logic               layer_start,
  output logic [LAYER_W-1:0] layer_idx,
  input  logic               layer_done,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               busy,
  output logic               timeout_err,
  output logic [15:0]        frame_count
);

  localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LAYER_W-1:0] LAST_IDX  = LAYER_W'(NUM_LAYERS - 1);
  // Compare against TIMEOUT-1: the counter reads 0 in the first WAIT cycle.
  localparam logic [WDOG_W-1:0]  WDOG_LAST = WDOG_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t               state_q;
  logic                 frame_ready_q;
  logic                 first_q;
  logic                 layer_start_q;
  logic [LAYER_W-1:0]   layer_idx_q;
  logic                 result_valid_q;
  logic                 busy_q;
  logic                 timeout_err_q;
  logic [15:0]          frame_count_q;
  logic [WDOG_W-1:0]    wdog_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      frame_ready_q  <= 1'b1;
      first_q        <= 1'b0;
      layer_start_q  <= 1'b0;
      layer_idx_q    <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      frame_count_q  <= '0;
      wdog_q         <= '0;
    end else begin
      first_q       <= 1'b0;
      layer_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (frame_valid) begin
            state_q       <= S_LOAD;
            frame_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            timeout_err_q <= 1'b0;
            first_q       <= 1'b1;
            layer_idx_q   <= '0;
          end
        end
        S_LOAD: begin
          state_q       <= S_START;
          layer_start_q <= 1'b1;
        end
        S_START: begin
          state_q <= S_WAIT;
          wdog_q  <= '0;
        end
        S_WAIT: begin
          wdog_q <= wdog_q + 1'b1;
          // A completion on the expiry cycle takes priority over the abort.
          if (layer_done) begin
            if (layer_idx_q == LAST_IDX) begin
              state_q        <= S_RESULT;
              result_valid_q <= 1'b1;
            end else begin
              state_q       <= S_START;
              layer_idx_q   <= layer_idx_q + 1'b1;
              layer_start_q <= 1'b1;
            end
          end else if ((TIMEOUT != 0) && (wdog_q == WDOG_LAST)) begin
            state_q       <= S_IDLE;
            timeout_err_q <= 1'b1;
            frame_ready_q <= 1'b1;
            busy_q        <= 1'b0;
          end
        end
        S_RESULT: begin
          if (result_ready) begin
            state_q        <= S_IDLE;
            result_valid_q <= 1'b0;
            frame_count_q  <= frame_count_q + 16'd1;
            frame_ready_q  <= 1'b1;
            busy_q         <= 1'b0;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          frame_ready_q <= 1'b1;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign frame_ready  = frame_ready_q;
  assign first        = first_q;
  assign layer_start  = layer_start_q;
  assign layer_idx    = layer_idx_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_err_q;
  assign frame_count  = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fnn_layer_sequencer.sv
// ============================================================================
// tb_fnn_layer_sequencer : timeline-model bench for fnn_layer_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fnn_layer_sequencer;

  localparam int NL = 3;
  localparam int TO = 8;
  localparam int LW = (NL > 1) ? $clog2(NL) : 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_valid = 1'b0;
  logic          layer_done = 1'b0;
  logic          result_ready = 1'b0;
  logic          frame_ready;
  logic          first;
  logic          layer_start;
  logic [LW-1:0] layer_idx;
  logic          result_valid;
  logic          busy;
  logic          timeout_err;
  logic [15:0]   frame_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_m = 0;
  bit err_m = 1'b0;

  fnn_layer_sequencer #(.NUM_LAYERS(NL), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .first        (first),
    .layer_start  (layer_start),
    .layer_idx    (layer_idx),
    .layer_done   (layer_done),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rst(input string tag);
    check_eq({tag, ".frame_ready"},  32'(frame_ready),  32'd1);
    check_eq({tag, ".first"},        32'(first),        32'd0);
    check_eq({tag, ".layer_start"},  32'(layer_start),  32'd0);
    check_eq({tag, ".layer_idx"},    32'(layer_idx),    32'd0);
    check_eq({tag, ".result_valid"}, 32'(result_valid), 32'd0);
    check_eq({tag, ".busy"},         32'(busy),         32'd0);
    check_eq({tag, ".timeout_err"},  32'(timeout_err),  32'd0);
    check_eq({tag, ".frame_count"},  32'(frame_count),  32'd0);
  endtask

  // d[k]: cycles from layer k's start to its done; d[k] > TO means the layer hangs.
  // Times are relative to the acceptance cycle (t=0).
  task automatic run_frame(input int d[NL], input int rdy_lat, input bit early_next, input bit spur);
    int s[NL];
    int nst = 0, hung = -1, rv = -1, hs = -1, fin;
    for (int k = 0; k < NL; k++) begin
      s[k] = (k == 0) ? 2 : s[k-1] + d[k-1] + 1;
      nst = k + 1;
      if (d[k] > TO) begin
        hung = k;
        break;
      end
    end
    if (hung >= 0) begin
      fin = s[hung] + TO + 1;
    end else begin
      rv  = s[NL-1] + d[NL-1] + 1;
      hs  = rv + rdy_lat;
      fin = hs + 1;
    end

    check_eq("idle.frame_ready", 32'(frame_ready), 32'd1);
    check_eq("idle.timeout_err", 32'(timeout_err), 32'(err_m));
    check_eq("idle.frame_count", 32'(frame_count), 32'(cnt_m));
    frame_valid = 1'b1;
    layer_done  = spur ? 1'($urandom_range(0, 1)) : 1'b0;
    step();

    for (int t = 1; t <= fin; t++) begin
      bit ls_e = 1'b0, done_d = 1'b0;
      int idx_e = 0;
      bit busy_e = (t < fin);
      bit rv_e = (rv >= 0) && (t >= rv) && (t <= hs);
      bit terr_e = (t >= fin) && (hung >= 0);
      int cnt_e = (t >= fin && hung < 0) ? ((cnt_m + 1) % 65536) : cnt_m;
      for (int k = 0; k < nst; k++) begin
        if (s[k] == t) ls_e = 1'b1;
        if (s[k] <= t) idx_e = k;
      end
      check_eq("first",        32'(first),        32'(t == 1));
      check_eq("layer_start",  32'(layer_start),  32'(ls_e));
      check_eq("result_valid", 32'(result_valid), 32'(rv_e));
      check_eq("busy",         32'(busy),         32'(busy_e));
      check_eq("frame_ready",  32'(frame_ready),  32'(!busy_e));
      check_eq("timeout_err",  32'(timeout_err),  32'(terr_e));
      check_eq("frame_count",  32'(frame_count),  32'(cnt_e));
      if (busy_e) check_eq("layer_idx", 32'(layer_idx), 32'(idx_e));

      frame_valid = early_next && (t >= fin - 3);
      for (int k = 0; k < nst; k++)
        if (k != hung && s[k] + d[k] == t) done_d = 1'b1;
      if (spur && (t == 1 || ls_e || t == fin) && $urandom_range(0, 1) == 1) done_d = 1'b1;
      layer_done = done_d;
      if (rv >= 0 && t < rv) result_ready = 1'($urandom_range(0, 1));
      else if (rv >= 0)      result_ready = (t >= hs);
      else                   result_ready = 1'($urandom_range(0, 1));
      if (rdy_lat == 0 && rv >= 0 && t == rv - 1) result_ready = 1'b1;
      if (t < fin) step();
    end
    if (hung < 0) cnt_m = (cnt_m + 1) % 65536;
    err_m = (hung >= 0);
  endtask

  function automatic int rand_dly();
    int r = int'($urandom_range(0, 9));
    if (r == 0) return TO + 1;
    if (r == 1) return TO;
    return int'($urandom_range(1, TO - 1));
  endfunction

  task automatic reset_mid();
    frame_valid = 1'b1;
    layer_done  = 1'b0;
    step();
    frame_valid = 1'b0;
    for (int t = 1; t < 7; t++) begin
      if (t == 5) begin
        check_eq("rm.layer_start", 32'(layer_start), 32'd1);
        check_eq("rm.layer_idx",   32'(layer_idx),   32'd1);
      end
      layer_done = (t == 4);
      step();
    end
    layer_done = 1'b0;
    rst_n = 1'b0;
    step();
    check_rst("rm.reset");
    rst_n = 1'b1;
    cnt_m = 0;
    err_m = 1'b0;
    for (int t = 0; t < 4; t++) begin
      step();
      check_eq("rm.no_result", 32'(result_valid), 32'd0);
      check_eq("rm.idle",      32'(frame_ready),  32'd1);
    end
  endtask

  initial begin
    int dr[NL];
    rst_n = 1'b0;
    step();
    step();
    check_rst("reset");
    rst_n = 1'b1;
    step();

    run_frame('{5, 5, 5}, 0, 1'b0, 1'b0);
    run_frame('{2, 1, 3}, 10, 1'b1, 1'b1);
    run_frame('{1, 1, 1}, 0, 1'b0, 1'b0);
    run_frame('{3, TO + 1, 1}, 0, 1'b0, 1'b0);
    run_frame('{1, 2, 1}, 0, 1'b0, 1'b1);
    run_frame('{TO, TO, TO}, 1, 1'b0, 1'b1);

    force dut.frame_count_q = 16'hFFFF;
    #1;
    release dut.frame_count_q;
    cnt_m = 65535;
    check_eq("preload", 32'(frame_count), 32'hFFFF);
    run_frame('{1, 1, 1}, 0, 1'b0, 1'b0);
    check_eq("wrap", 32'(frame_count), 32'd0);

    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < NL; k++) dr[k] = rand_dly();
      run_frame(dr, int'($urandom_range(0, 4)), (i < 39) && ($urandom_range(0, 1) == 1), 1'b1);
    end

    reset_mid();
    run_frame('{2, 3, 1}, 2, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
